// File: rtl/cordic_atan_seq.sv
// Sequential CORDIC vectoring arctangent (degrees x 65536); optional mag output under CORDIC_MAG_EN.
// Latency: out_valid rises ITER+2 edges after the accept edge (accept, PRE, ITER rotations).
// Backpressure: in_ready only in IDLE; DONE holds out/out_valid until out_ready.
module cordic_atan_seq #(
    parameter int ITER = 16,
    parameter int W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] inx,
    input  logic signed [W-1:0] iny,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out,
    output logic                busy
`ifdef CORDIC_MAG_EN
    ,
    output logic [W+1:0]        mag
`endif
);
    localparam int IW = $clog2(ITER);
    localparam logic [IW-1:0] ILAST = IW'(ITER - 1);
    localparam logic signed [W-1:0] Z_P90 = W'(5898240);
    localparam logic signed [W-1:0] Z_N90 = W'(-5898240);

    typedef enum logic [1:0] {IDLE, PRE, ROT, DONE} state_t;

    state_t              state, state_n;
    logic signed [W+1:0] x, y, xr, yr, xs, ys;
    logic signed [W-1:0] z, zr;
    logic [IW-1:0]       i;
    logic                zero_flag;
    logic                last;

    function automatic logic signed [W-1:0] atan_lut(input logic [4:0] k);
        logic signed [W-1:0] v;
        case (k)
            5'd0:    v = 2949120;
            5'd1:    v = 1740967;
            5'd2:    v = 919879;
            5'd3:    v = 466945;
            5'd4:    v = 234379;
            5'd5:    v = 117304;
            5'd6:    v = 58666;
            5'd7:    v = 29335;
            5'd8:    v = 14668;
            5'd9:    v = 7334;
            5'd10:   v = 3667;
            5'd11:   v = 1833;
            5'd12:   v = 917;
            5'd13:   v = 458;
            5'd14:   v = 229;
            5'd15:   v = 115;
            5'd16:   v = 57;
            5'd17:   v = 29;
            5'd18:   v = 14;
            5'd19:   v = 7;
            5'd20:   v = 4;
            5'd21:   v = 2;
            5'd22:   v = 1;
            default: v = '0;
        endcase
        return v;
    endfunction

    assign last = (i == ILAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        out       = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_n = PRE;
            end
            PRE: state_n = ROT;
            ROT: if (last) state_n = DONE;
            DONE: begin
                out_valid = 1'b1;
                out       = zero_flag ? '0 : z;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // One micro-rotation: drive y toward zero, accumulate the rotated angle in z.
    always_comb begin
        xs = x >>> i;
        ys = y >>> i;
        if (!y[W+1]) begin
            xr = x + ys;
            yr = y - xs;
            zr = z + atan_lut(5'(i));
        end else begin
            xr = x - ys;
            yr = y + xs;
            zr = z - atan_lut(5'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            i         <= '0;
            zero_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x <= {{2{inx[W-1]}}, inx};
                    y <= {{2{iny[W-1]}}, iny};
                    z <= '0;
                end
                PRE: begin
                    zero_flag <= (x == '0) && (y == '0);
                    i         <= '0;
                    // Fold the left half-plane into the right so rotations cover the residual.
                    if (x[W+1] && !y[W+1]) begin
                        x <= y;
                        y <= -x;
                        z <= Z_P90;
                    end else if (x[W+1]) begin
                        x <= -y;
                        y <= x;
                        z <= Z_N90;
                    end else begin
                        z <= '0;
                    end
                end
                ROT: begin
                    x <= xr;
                    y <= yr;
                    z <= zr;
                    i <= last ? '0 : i + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CORDIC_MAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  mag <= '0;
        else if (state == ROT && last) mag <= zero_flag ? '0 : xr;
    end
`endif

endmodule

// File: doc/cordic_atan_seq.md
# cordic_atan_seq

Iterative, sequential CORDIC vectoring-mode arctangent engine with a valid/ready front end and back end. It is the clocked, shared-resource replacement for the combinational arctan datapath. A single add/shift stage is reused for ITER cycles, sequenced by an internal FSM and iteration counter. Upstream producers hand it (x, y) pairs; downstream consumes theta.

## Interface
- ITER, 16: number of CORDIC micro-rotations (legal range 8..24).
- W, 32: width of inx, iny and out.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pair present.
- in_ready  out  1  engine can accept a pair (high only in IDLE).
- inx  in  W  signed x.
- iny  in  W  signed y.
- out_valid  out  1  theta valid, held until taken.
- out_ready  in  1  consumer accepts theta.
- out  out  W  signed angle, degrees × 65536 (2^-16 deg LSB), range (-180°, +180°].
- busy  out  1  high in PRE, ROT or DONE.
- mag  out  W+2  unscaled magnitude (CORDIC_MAG_EN only).

## Operation
- FSM states: IDLE, PRE, ROT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch inx/iny into internal x,y (sign-extended to W+2 bits), clear z, go PRE.
- PRE (quadrant pre-rotation, 1 cycle):
  - x<0, y>=0: (x,y)←(y,−x), z←+90°=5898240.
  - x<0, y<0: (x,y)←(−y,x), z←−90°=−5898240.
  - Otherwise no change, z←0.
  - Set zero_flag if the latched x==0 and y==0.
  - Clear iteration counter i. Go ROT.
- ROT (one micro-rotation per cycle, i=0..ITER−1):
  - y>=0: x←x+(y>>>i), y←y−(x>>>i), z←z+ATAN[i].
  - y<0: x←x−(y>>>i), y←y+(x>>>i), z←z−ATAN[i].
  - Shifts are arithmetic.
  - After i==ITER−1, go DONE.
- ATAN[i] = round(atan(2^-i)·180/π·65536), a constant ROM. First entries: 2949120, 1740967, 919879, 466945, 234379, 117304.
- DONE: out_valid=1. out=z (truncated to W), or 0 if zero_flag. out is stable while out_valid is high. On out_ready, go IDLE and drop out_valid.
- Result +180° arises only from x<0, y=0. −180° is never produced.
- in_valid while not IDLE is ignored; the producer must hold its pair.

## Timing
- Reset values: in_ready=1, out_valid=0, out=0, busy=0, mag=0, state=IDLE, i=0.
- Accept edge → out_valid high after exactly ITER+2 rising edges (PRE + ITER ROT + DONE entry). The latency is independent of data and zero_flag.
- Back-to-back throughput: one result per ITER+3 cycles minimum (the DONE→IDLE handshake costs one cycle). No acceptance occurs in the cycle out_ready is taken.
- Back-pressure: DONE holds indefinitely with out/out_valid constant until out_ready=1.
- rst asserted in any state: immediate return to reset values, and any in-flight operation is discarded. After deassertion, the first edge may accept.
- The out_ready sample is ignored when out_valid=0.

## Configuration
- CORDIC_MAG_EN defined: the mag port exists. It is updated in DONE with the final internal x, which is magnitude × K, K≈1.64676 (gain not compensated). mag=0 when zero_flag is set. The reset value is 0.
- CORDIC_MAG_EN undefined: the mag port and its register are absent. All other behaviour is identical.

## Test plan
- Reset then (inx,iny)=(65536,65536) → out_valid after ITER+2 edges; out=2949120±200; busy high throughout.
- (−65536,0) → out=11796480±200 (+180°); (−65536,−65536) → −8847360±200 (−135°).
- (0,0) → out=0 exactly at standard latency; mag=0 when CORDIC_MAG_EN is defined.
- Hold out_ready=0 for 20 cycles in DONE → out/out_valid unchanged and in_ready=0. Raise out_ready → IDLE next edge, then accept (0,−65536) → −5898240±200.
- Assert rst mid-ROT (i=5) → all outputs at reset values immediately. Next pair (65536,0) → 0±200 with full latency.
- Replay the 19-vector x/y/theta file set through the handshake. All results must be within ±200 LSB. With CORDIC_MAG_EN: (3·65536, 4·65536) → mag≈5·65536·1.64676±64.
